// File: rtl/des_pkg.sv
// Shared types, sizing constants and DES permutation / substitution tables.
// Bit 0 of every [0:N] vector is the leftmost DES bit, so the 1-based table
// entries map directly onto position (entry - 1).
package des_pkg;

  typedef logic [0:31]       half_t;
  typedef logic [0:63]       block_t;
  typedef logic [0:47]       round_key_t;
  typedef logic [0:15][0:47] key_bank_t;

  typedef enum logic [0:0] {IDLE, ROUND} state_e;

  localparam int ROUNDS_PER_STAGE = 16;
  localparam int TOTAL_ROUNDS     = 48;

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each box is stored row-major: entry = row * 16 + column.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  function automatic block_t ip_perm(input block_t x);
    block_t y;
    for (int i = 0; i < 64; i++) y[6'(i)] = x[6'(IP_TBL[6'(i)] - 1)];
    return y;
  endfunction

  function automatic block_t fp_perm(input block_t x);
    block_t y;
    for (int i = 0; i < 64; i++) y[6'(i)] = x[6'(FP_TBL[6'(i)] - 1)];
    return y;
  endfunction

endpackage

// File: rtl/des_feistel_function.sv
// Combinational DES round function f(R, K): expand, key mix, S-boxes, P.
module des_feistel_function
  import des_pkg::*;
(
  input  half_t      r_i,
  input  round_key_t k_i,
  output half_t      f_o
);

  logic [0:47] mix;
  logic [0:31] sub;
  logic [0:5]  chunk;
  logic [5:0]  sel;

  // Expansion and key XOR, then each 6-bit chunk picks a row from its outer
  // bits and a column from its inner four, and the result is permuted by P.
  always_comb begin
    mix   = '0;
    sub   = '0;
    chunk = '0;
    sel   = '0;
    f_o   = '0;
    for (int i = 0; i < 48; i++) mix[6'(i)] = r_i[5'(E_TBL[6'(i)] - 1)] ^ k_i[6'(i)];
    for (int s = 0; s < 8; s++) begin
      chunk = mix[6'(6 * s) +: 6];
      sel   = {chunk[0], chunk[5], chunk[1:4]};
      sub[5'(4 * s) +: 4] = 4'(SBOX[3'(s)][sel]);
    end
    for (int i = 0; i < 32; i++) f_o[5'(i)] = sub[5'(P_TBL[5'(i)] - 1)];
  end

endmodule

// File: rtl/des3_round_engine.sv
// Iterative Triple-DES (EDE) engine: one Feistel round per clock, IP on load,
// FP on completion. Stage-final rounds skip the half swap, which absorbs the
// DES output swap and the FP/IP pair that would cancel between stages.
//
//   state | meaning
//   IDLE  | waiting for start; data_out holds the last result
//   ROUND | running round cnt (0..LAST), busy high
module des3_round_engine
  import des_pkg::*;
#(
  parameter bit SINGLE_DES = 1'b0
) (
  input  logic      clk_i,
  input  logic      reset_i,
  input  logic      start_i,
  input  block_t    data_in_i,
  input  key_bank_t round_keys_1_i,
  input  key_bank_t round_keys_2_i,
  input  key_bank_t round_keys_3_i,
  output logic      busy_o,
  output logic      done_o,
  output block_t    data_out_o
);

  localparam logic [5:0] LAST = SINGLE_DES ? 6'(ROUNDS_PER_STAGE - 1) : 6'(TOTAL_ROUNDS - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  half_t      l_q, l_d, r_q, r_d;
  logic       busy_q, busy_d, done_q, done_d;
  block_t     dout_q, dout_d;
  block_t     ip_blk;
  round_key_t round_key;
  half_t      f_out;
  logic [1:0] stage;
  logic [3:0] idx;

  assign stage = cnt_q[5:4];
  assign idx   = cnt_q[3:0];

  // Key mux: the middle stage walks its bank backwards to run the opposite direction.
  always_comb begin
    case (stage)
      2'd0:    round_key = round_keys_1_i[idx];
      2'd1:    round_key = round_keys_2_i[4'd15 - idx];
      default: round_key = round_keys_3_i[idx];
    endcase
  end

  des_feistel_function u_feistel (
    .r_i (r_q),
    .k_i (round_key),
    .f_o (f_out)
  );

  // Next-state and datapath update for the load / round / finish sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    ip_blk  = ip_perm(data_in_i);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ROUND;
          cnt_d   = '0;
          l_d     = ip_blk[0:31];
          r_d     = ip_blk[32:63];
          busy_d  = 1'b1;
        end
      end
      ROUND: begin
        cnt_d = cnt_q + 6'd1;
        if (idx == 4'd15) begin
          l_d = l_q ^ f_out;
        end else begin
          l_d = r_q;
          r_d = l_q ^ f_out;
        end
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dout_d  = fp_perm({l_q ^ f_out, r_q});
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any block in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign data_out_o = dout_q;

endmodule

// File: tb/tb_des3_round_engine.sv
// Directed known-answer bench for the 3DES round engine (EDE and single-DES builds).
// Edge counts include the edge that accepts start, so done after the 49th
// (EDE) or 17th (single DES) counted edge means the nominal latency.
module tb_des3_round_engine;
  import des_pkg::*;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic      clk;
  logic      reset;
  logic      start_e, start_s;
  block_t    data_in;
  key_bank_t k1, k2, k3;
  key_bank_t k1_prev, k2_prev, k3_prev;
  logic      busy_e, done_e, busy_s, done_s;
  block_t    dout_e, dout_s;

  int n_chk = 0;
  int n_err = 0;

  des3_round_engine #(.SINGLE_DES(1'b0)) dut_e (
    .clk_i(clk), .reset_i(reset), .start_i(start_e), .data_in_i(data_in),
    .round_keys_1_i(k1), .round_keys_2_i(k2), .round_keys_3_i(k3),
    .busy_o(busy_e), .done_o(done_e), .data_out_o(dout_e));

  des3_round_engine #(.SINGLE_DES(1'b1)) dut_s (
    .clk_i(clk), .reset_i(reset), .start_i(start_s), .data_in_i(data_in),
    .round_keys_1_i(k1), .round_keys_2_i(k2), .round_keys_3_i(k3),
    .busy_o(busy_s), .done_o(done_s), .data_out_o(dout_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keys must not move while the EDE engine is working on a block.
  always @(posedge clk) begin
    if (busy_e === 1'b1)
      assert (k1 == k1_prev && k2 == k2_prev && k3 == k3_prev)
        else $error("FAIL key_stable: round keys changed while busy");
    k1_prev <= k1;
    k2_prev <= k2;
    k3_prev <= k3;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Standard DES key schedule; decrypt order is the encrypt bank reversed.
  function automatic key_bank_t key_sched(input logic [0:63] key, input bit decrypt);
    logic [0:55] cd;
    logic [0:27] c, d;
    logic [0:47] sk;
    key_bank_t   bank;
    bank = '0;
    for (int i = 0; i < 56; i++) cd[6'(i)] = key[6'(PC1[6'(i)] - 1)];
    c = cd[0:27];
    d = cd[28:55];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[4'(r)]; s++) begin
        c = {c[1:27], c[0]};
        d = {d[1:27], d[0]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) sk[6'(j)] = cd[6'(PC2[6'(j)] - 1)];
      if (decrypt) bank[4'(15 - r)] = sk;
      else         bank[4'(r)]      = sk;
    end
    return bank;
  endfunction

  task automatic set_keys(input logic [63:0] ka, input logic [63:0] kb, input logic [63:0] kc,
                          input bit decrypt);
    if (decrypt) begin
      k1 = key_sched(kc, 1'b1);
      k2 = key_sched(kb, 1'b1);
      k3 = key_sched(ka, 1'b1);
    end else begin
      k1 = key_sched(ka, 1'b0);
      k2 = key_sched(kb, 1'b0);
      k3 = key_sched(kc, 1'b0);
    end
  endtask

  // Start one block on the chosen engine, optionally pulse start again while
  // busy, and return the result, edges up to done and busy cycle count.
  task automatic run_block(input bit sgl, input block_t din, input int pulse_at,
                           output block_t dout, output int edges, output int busy_cyc);
    @(negedge clk);
    data_in = din;
    if (sgl) start_s = 1'b1; else start_e = 1'b1;
    @(posedge clk);
    edges    = 1;
    busy_cyc = 0;
    dout     = '0;
    while (edges < 80) begin
      @(negedge clk);
      data_in = ~din;
      if (sgl) start_s = (edges == pulse_at); else start_e = (edges == pulse_at);
      if (sgl ? busy_s : busy_e) busy_cyc++;
      if (sgl ? done_s : done_e) begin
        dout = sgl ? dout_s : dout_e;
        break;
      end
      @(posedge clk);
      edges++;
    end
    start_s = 1'b0;
    start_e = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  block_t ct, res;
  int     edges, busy_cyc, cyc, last_done, n_done;
  logic [63:0] b2b_key [3];
  logic [63:0] b2b_pt  [3];
  logic [63:0] b2b_ct  [3];

  initial begin
    reset   = 1'b1;
    start_e = 1'b1;
    start_s = 1'b1;
    data_in = 64'h0123456789ABCDEF;
    k1 = '0; k2 = '0; k3 = '0;

    // Reset held with start asserted: nothing accepted, outputs cleared.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_busy", 64'(busy_e), 64'd0);
      chk("rst_done", 64'(done_e), 64'd0);
      chk("rst_dout", dout_e, 64'd0);
    end
    reset   = 1'b0;
    start_e = 1'b0;
    start_s = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 64'(busy_e), 64'd0);

    // Single DES known answer.
    set_keys(64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 1'b0);
    run_block(1'b1, 64'h0123456789ABCDEF, 0, res, edges, busy_cyc);
    chk("sdes_kat", res, 64'h85E813540F0AB405);
    chk("sdes_latency", 64'(edges), 64'd17);
    chk("sdes_busy", 64'(busy_cyc), 64'd16);

    // EDE with one key collapses to single DES.
    run_block(1'b0, 64'h0123456789ABCDEF, 0, res, edges, busy_cyc);
    chk("ede_kat", res, 64'h85E813540F0AB405);
    chk("ede_latency", 64'(edges), 64'd49);
    chk("ede_busy", 64'(busy_cyc), 64'd48);
    @(negedge clk);
    chk("done_pulse", 64'(done_e), 64'd0);
    chk("dout_hold", dout_e, 64'h85E813540F0AB405);

    // Distinct-key round trip, with a stray start pulse during the decrypt.
    set_keys(64'h0123456789ABCDEF, 64'h23456789ABCDEF01, 64'h456789ABCDEF0123, 1'b0);
    run_block(1'b0, 64'h4E6F772069732074, 0, ct, edges, busy_cyc);
    chk("rt_ct_differs", 64'(ct != 64'h4E6F772069732074), 64'd1);
    chk("rt_enc_latency", 64'(edges), 64'd49);
    set_keys(64'h0123456789ABCDEF, 64'h23456789ABCDEF01, 64'h456789ABCDEF0123, 1'b1);
    run_block(1'b0, ct, 10, res, edges, busy_cyc);
    chk("rt_plaintext", res, 64'h4E6F772069732074);
    chk("rt_dec_latency", 64'(edges), 64'd49);

    // Back-to-back: start held high, keys swapped in the idle cycle after done.
    b2b_key = '{64'h0E329232EA6D0D73, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF};
    b2b_pt  = '{64'h8787878787878787, 64'h0123456789ABCDEF, 64'h4E6F772069732074};
    b2b_ct  = '{64'h0000000000000000, 64'h85E813540F0AB405, 64'h3FA40E8A984D4815};
    @(negedge clk);
    set_keys(b2b_key[0], b2b_key[0], b2b_key[0], 1'b0);
    data_in   = b2b_pt[0];
    start_e   = 1'b1;
    cyc       = 0;
    last_done = 0;
    n_done    = 0;
    while (n_done < 3 && cyc < 300) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done_e) begin
        chk("b2b_dout", dout_e, b2b_ct[n_done]);
        if (n_done > 0) chk("b2b_gap", 64'(cyc - last_done), 64'd49);
        last_done = cyc;
        n_done++;
        if (n_done < 3) begin
          set_keys(b2b_key[n_done], b2b_key[n_done], b2b_key[n_done], 1'b0);
          data_in = b2b_pt[n_done];
        end else begin
          start_e = 1'b0;
        end
      end
    end
    start_e = 1'b0;
    chk("b2b_count", 64'(n_done), 64'd3);

    // Reset at cnt=20 aborts the block; a fresh block then runs normally.
    @(negedge clk);
    data_in = 64'h0123456789ABCDEF;
    start_e = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_e = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_busy_before", 64'(busy_e), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", 64'(busy_e), 64'd0);
    chk("mid_rst_done", 64'(done_e), 64'd0);
    chk("mid_rst_dout", dout_e, 64'd0);
    repeat (30) @(negedge clk);
    chk("mid_no_done", 64'(done_e), 64'd0);
    run_block(1'b0, 64'h0123456789ABCDEF, 0, res, edges, busy_cyc);
    chk("mid_after_kat", res, 64'h3FA40E8A984D4815 ^ 64'h3FA40E8A984D4815 ^ 64'h56CC09E7CFDC4CEF);
    chk("mid_after_latency", 64'(edges), 64'd49);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
